muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/muldiv_iter_step.sv | 54 +++++
 rtl/muldiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32 M-extension definitions: datapath widths, funct3 op codes and
// the multiply/divide sequencer state encoding.
package rv32i_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the multiply/divide datapath on a 64-bit
// accumulator.
//   div_i  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i  : accumulator {hi, lo} before the step
//   opnd_i : divisor magnitude (divide) or multiplicand magnitude (multiply)
//   acc_o  : accumulator after the step
// Optional feature macro: MULDIV_MUL_EN (multiply step only built when defined).
module muldiv_iter_step
  import rv32i_pkg::*;
(
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN+1:0]   trial;
  logic [2*XLEN-1:0] div_acc;
  logic              unused_trial;

  // Restoring divide: shift {rem, quo} left, try subtracting the divisor from
  // the 33-bit partial remainder; keep it and shift in a 1 when no borrow.
  always_comb begin
    trial = {1'b0, acc_i[2*XLEN-1:XLEN-1]} - {2'b00, opnd_i};
    if (trial[XLEN+1]) begin
      div_acc = {acc_i[2*XLEN-2:0], 1'b0};
    end else begin
      div_acc = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end
  end

  // Without a borrow the difference is below the divisor, so bit XLEN is zero.
  assign unused_trial = trial[XLEN];

`ifdef MULDIV_MUL_EN
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_acc;

  // Shift-add multiply: add multiplicand into the high half when the current
  // multiplier bit (lo[0]) is set, then shift the 65-bit result right.
  always_comb begin
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    mul_acc = {sum, acc_i[XLEN-1:1]};
  end

  assign acc_o = div_i ? div_acc : mul_acc;
`else
  logic unused_div;

  assign unused_div = div_i;
  assign acc_o      = div_acc;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32 M-extension multiply/divide sequencer for the EX stage.
// One iteration per cycle for 32 cycles; divide-by-zero and signed overflow
// complete on the cycle after acceptance.
//   clk, rst (async, active-low)
//   start_i, op_i, a_i, b_i, rd_i : op issue from EX
//   flush_i                       : kill the in-flight op
//   stall_o                       : hold IF/ID/EX (combinational)
//   busy_o, done_o                : state flags; done_o pulses for one cycle
//   result_o, rd_o                : result and destination, valid with done_o
// Optional feature macro: MULDIV_MUL_EN (multiply ops; absent -> result 0).
module muldiv_sequencer
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              accept, last_iter, special, div_zero, div_ovf;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, final_res;
  logic [XLEN-1:0]   quo, rem;

  assign accept    = (state_q == ST_IDLE) & start_i & ~flush_i;
  assign last_iter = (state_q == ST_CALC) & (cnt_q == CNT_W'(XLEN - 1));
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign result_o  = result_q;
  assign rd_o      = rd_out_q;

  // Issue decode: operand signedness, magnitudes and the direct-path cases.
  always_comb begin
    a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg    = a_signed & a_i[XLEN-1];
    b_neg    = b_signed & b_i[XLEN-1];
    a_mag    = a_neg ? (~a_i + XLEN'(1)) : a_i;
    b_mag    = b_neg ? (~b_i + XLEN'(1)) : b_i;
    div_zero = op_i[2] & (b_i == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (a_i == INT_MIN) & (&b_i);
    special  = div_zero | div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? a_i : '1;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : INT_MIN;
    end
`ifndef MULDIV_MUL_EN
    if (!op_i[2]) begin
      special = 1'b1;
    end
`endif
  end

  muldiv_iter_step u_step (
    .div_i  (op_q[2]),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Sign fix-up of the final iteration's accumulator; remainder follows dividend.
  assign quo = step_acc[XLEN-1:0];
  assign rem = step_acc[2*XLEN-1:XLEN];

`ifdef MULDIV_MUL_EN
  logic [2*XLEN-1:0] prod;

  always_comb begin
    prod = neg_quo_q ? (~step_acc + (2*XLEN)'(1)) : step_acc;
    if (!op_q[2]) begin
      final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (op_q[1]) begin
      final_res = neg_rem_q ? (~rem + XLEN'(1)) : rem;
    end else begin
      final_res = neg_quo_q ? (~quo + XLEN'(1)) : quo;
    end
  end
`else
  logic unused_op;

  assign unused_op = op_q[0];

  always_comb begin
    if (op_q[1]) begin
      final_res = neg_rem_q ? (~rem + XLEN'(1)) : rem;
    end else begin
      final_res = neg_quo_q ? (~quo + XLEN'(1)) : quo;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs and datapath next values
  always_comb begin
    stall_o   = accept | (state_q == ST_CALC);
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    if (accept) begin
      cnt_d     = '0;
      op_d      = op_i;
      rd_d      = rd_i;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      // divide: lo = dividend, operand = divisor; multiply: lo = multiplier
      acc_d     = {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
      opnd_d    = op_i[2] ? b_mag : a_mag;
      if (special) begin
        result_d = special_res;
        rd_out_d = rd_i;
      end
    end else if ((state_q == ST_CALC) && !flush_i) begin
      acc_d = step_acc;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        result_d = final_res;
        rd_out_d = rd_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner ops, flush and
// reset abort, then randomized ops against an arithmetic reference model.
// Honors MULDIV_MUL_EN the same way as the design.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    longint      sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 33;
    r   = '0;
    p   = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'h0, b})); r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h8000_0000; lat = 1; end
        else r = 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) begin r = a; lat = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h0; lat = 1; end
        else r = 32'(sa % sb);
      end
      default: begin
        if (b == 0) begin r = a; lat = 1; end
        else r = a % b;
      end
    endcase
`ifndef MULDIV_MUL_EN
    if (!op[2]) begin
      r   = '0;
      lat = 1;
    end
`endif
  endfunction

  // Issue one op and follow it to completion, checking stall, latency,
  // result, rd and the single-cycle done pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    bit          got;
    model(op, a, b, exp_r, exp_lat);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    #1 check_eq("stall_on_start", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs: the sequencer must have captured them, and start_i
    // outside IDLE must be ignored.
    start_i = 1'($urandom_range(0, 1));
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom; rd_i = 5'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done_o) begin
        got = 1'b1;
      end else begin
        check_eq("stall_calc", 32'(stall_o), 32'd1);
        start_i = (lat < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    start_i = 1'b0;
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("result", result_o, exp_r);
    check_eq("rd", 32'(rd_o), 32'(rd));
    check_eq("stall_on_done", 32'(stall_o), 32'd0);
    check_eq("busy_on_done", 32'(busy_o), 32'd1);
    @(negedge clk);
    check_eq("done_single", 32'(done_o), 32'd0);
    check_eq("busy_after", 32'(busy_o), 32'd0);
    check_eq("result_hold", result_o, exp_r);
    check_eq("rd_hold", 32'(rd_o), 32'(rd));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected TB_RESULT");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          mode;

    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_rd", 32'(rd_o), 32'd0);
    rst = 1'b1;

    // Directed corner ops
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'd5, 32'd100, 32'd0, 5'd6);
    run_op(3'd7, 32'd100, 32'd0, 5'd7);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10);

    // Flush in cycle N+10 kills the op; a new op in N+12 completes at N+45
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd5; a_i = 32'd1000; b_i = 32'd7; rd_i = 5'd11;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    check_eq("flush_busy_pre", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("flush_busy", 32'(busy_o), 32'd0);
    check_eq("flush_done", 32'(done_o), 32'd0);
    run_op(3'd5, 32'd12345, 32'd10, 5'd12);

    // Reset mid-op aborts with all outputs zero, then a fresh op runs
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd7; a_i = 32'd999; b_i = 32'd5; rd_i = 5'd13;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_stall", 32'(stall_o), 32'd0);
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_done", 32'(done_o), 32'd0);
    check_eq("abort_result", result_o, 32'd0);
    check_eq("abort_rd", 32'(rd_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 5'd14);

    // Randomized ops, biased toward the direct-path corners
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        r_b = '0;
      end else if (mode == 1) begin
        r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF;
      end else if (mode == 2) begin
        r_a = 32'($signed(32'($urandom_range(0, 200))) - 100);
        r_b = 32'($signed(32'($urandom_range(0, 20))) - 10);
      end
      run_op(r_op, r_a, r_b, 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
